boot_loader_ctrl: RTL

Serial-protocol memory loader that sits between the UART byte receiver/transmitter and the CPU's program memory.
- Parses command frames, writes or dumps memory words of configurable width, and holds the CPU in reset while loading.
- Parametrised successor of the single-mode bootloader: adds generic data/address widths, checksummed frames, ACK/NAK responses, read-back and an inter-byte timeout.

---
 rtl/boot_loader_pkg.sv | 23 ++
 rtl/boot_timeout_ctr.sv | 38 +++
 rtl/boot_loader_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_pkg.sv
// Shared constants, FSM state encoding and frame-geometry helpers for the boot loader.
package boot_loader_pkg;

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] CmdGo    = 8'h47;
  localparam logic [7:0] RespAck  = 8'h06;
  localparam logic [7:0] RespNak  = 8'h15;

  typedef enum logic [3:0] {
    StIdle, StAddr, StCnt, StData, StWrite, StCsum,
    StRdReq, StRdWait, StRdSend, StRdCsum, StResp
  } state_e;

  function automatic int unsigned bytes_per_word(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned addr_bytes(input int unsigned addr_w);
    return (addr_w + 7) / 8;
  endfunction

endpackage

// File: rtl/boot_timeout_ctr.sv
// Loadable down-counter for the inter-byte timeout; expire flags the last enabled cycle.
module boot_timeout_ctr #(
  parameter int unsigned LOAD_VAL = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = $clog2(LOAD_VAL + 1);
  localparam logic [W-1:0] Load = W'(LOAD_VAL);
  localparam logic [W-1:0] One = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = Load;
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - One;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= Load;
    end else if (ce) begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && !clear && (cnt_q == One);

endmodule

// File: rtl/boot_loader_ctrl.sv
// Serial command-frame memory loader (write / read-back / go) with CPU hold control.
// Optional BOOT_SCAN_EN adds scan_req, which dumps the whole memory in read-frame format.
module boot_loader_ctrl
  import boot_loader_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef BOOT_SCAN_EN
  input  logic              scan_req,
`endif
  output logic              cpu_hold,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned Bpw  = bytes_per_word(DATA_W);
  localparam int unsigned Ab   = addr_bytes(ADDR_W);
  localparam int unsigned CntW = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
  localparam logic [2:0] BpwLast = 3'(Bpw - 1);
  localparam logic [2:0] AbLast  = 3'(Ab - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [7:0]        sum_q, sum_d, resp_q, resp_d, sum_rx;
  logic              is_read_q, is_read_d, cpu_hold_q, cpu_hold_d, overrun_q, overrun_d;
  logic              in_rx, expire;

  assign in_rx  = state_q inside {StAddr, StCnt, StData, StCsum};
  assign sum_rx = sum_q + rx_data;

  boot_timeout_ctr #(.LOAD_VAL(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .ce     (ce),
    .clear  (rx_valid || !in_rx),
    .en     (in_rx),
    .expire (expire)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    word_d     = word_q;
    sum_d      = sum_q;
    resp_d     = resp_q;
    is_read_d  = is_read_q;
    cpu_hold_d = cpu_hold_q;
    overrun_d  = overrun_q;
    unique case (state_q)
      StIdle: begin
`ifdef BOOT_SCAN_EN
        if (scan_req) begin
          addr_d         = '0;
          cnt_d          = '0;
          cnt_d[ADDR_W]  = 1'b1;
          sum_d          = '0;
          state_d        = StRdReq;
          if (rx_valid) overrun_d = 1'b1;
        end else
`endif
        if (rx_valid) begin
          sum_d = '0;
          idx_d = '0;
          if (rx_data == CmdWrite) begin
            is_read_d  = 1'b0;
            cpu_hold_d = 1'b1;
            state_d    = StAddr;
          end else if (rx_data == CmdRead) begin
            is_read_d = 1'b1;
            state_d   = StAddr;
          end else if (rx_data == CmdGo) begin
            cpu_hold_d = 1'b0;
            resp_d     = RespAck;
            state_d    = StResp;
          end else begin
            resp_d  = RespNak;
            state_d = StResp;
          end
        end
      end
      StAddr: if (rx_valid) begin
        sum_d  = sum_rx;
        addr_d = ADDR_W'({addr_q, rx_data});
        idx_d  = idx_q + 3'd1;
        if (idx_q == AbLast) begin
          idx_d   = '0;
          state_d = StCnt;
        end
      end
      StCnt: if (rx_valid) begin
        cnt_d = (rx_data == 8'h00) ? CntW'(256) : CntW'(rx_data);
        // Read trailer covers data bytes only, so restart the sum here.
        sum_d   = is_read_q ? 8'h00 : sum_rx;
        state_d = is_read_q ? StRdReq : StData;
      end
      StData: if (rx_valid) begin
        sum_d  = sum_rx;
        word_d = DATA_W'({word_q, rx_data});
        idx_d  = idx_q + 3'd1;
        if (idx_q == BpwLast) begin
          idx_d   = '0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q - CntOne;
        state_d = (cnt_q == CntOne) ? StCsum : StData;
      end
      StCsum: if (rx_valid) begin
        resp_d  = (sum_rx == 8'h00) ? RespAck : RespNak;
        state_d = StResp;
      end
      StRdReq:  state_d = StRdWait;
      StRdWait: begin
        word_d  = mem_rdata;
        idx_d   = '0;
        state_d = StRdSend;
      end
      StRdSend: if (tx_ready) begin
        sum_d  = sum_q + word_q[DATA_W-1 -: 8];
        word_d = DATA_W'({word_q, 8'h00});
        idx_d  = idx_q + 3'd1;
        if (idx_q == BpwLast) begin
          idx_d   = '0;
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - CntOne;
          state_d = (cnt_q == CntOne) ? StRdCsum : StRdReq;
        end
      end
      StRdCsum: if (tx_ready) state_d = StIdle;
      StResp:   if (tx_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (in_rx && expire) begin
      resp_d  = RespNak;
      state_d = StResp;
    end
    if (rx_valid && !in_rx && state_q != StIdle) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      sum_q      <= '0;
      resp_q     <= '0;
      is_read_q  <= 1'b0;
      cpu_hold_q <= 1'b1;
      overrun_q  <= 1'b0;
    end else if (ce) begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      sum_q      <= sum_d;
      resp_q     <= resp_d;
      is_read_q  <= is_read_d;
      cpu_hold_q <= cpu_hold_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    unique case (state_q)
      StRdSend: begin
        tx_valid = 1'b1;
        tx_data  = word_q[DATA_W-1 -: 8];
      end
      StRdCsum: begin
        tx_valid = 1'b1;
        tx_data  = 8'h00 - sum_q;
      end
      StResp: begin
        tx_valid = 1'b1;
        tx_data  = resp_q;
      end
      default: ;
    endcase
  end

  assign mem_we    = (state_q == StWrite);
  assign mem_re    = (state_q == StRdReq);
  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;
  assign cpu_hold  = cpu_hold_q;
  assign busy      = (state_q != StIdle);
  assign overrun   = overrun_q;

endmodule
